// File: rtl/cf_uart_rx_deframer.sv
// rtl/cf_uart_rx_deframer.sv - UART receive deframer: oversampled start/data/parity/stop checking to a valid/ready word port
module cf_uart_rx_deframer #(
    parameter int MDW = 9,
    parameter int OVS = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           en_i,
    input  logic           tick_i,
    input  logic           rx_i,
    input  logic [3:0]     data_size_i,
    input  logic           stop2_i,
    input  logic [2:0]     parity_i,
    output logic [MDW-1:0] rdata_o,
    output logic           r_perr_o,
    output logic           r_ferr_o,
    output logic           rvalid_o,
    input  logic           rready_i,
    output logic           brk_o,
    output logic           overrun_o,
    output logic           busy_o
);

    localparam int             CW   = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [CW-1:0]  HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0]  LAST = CW'(OVS - 1);
    localparam logic [3:0]     MDW4 = 4'(MDW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t          state_q;
    logic            rx_s1_q, rx_s2_q, prev_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      bit_q;
    logic [3:0]      nbits_q;
    logic            stop2_q;
    logic [2:0]      par_q;
    logic [MDW-1:0]  data_q;
    logic            perr_q, ferr_q, pbit_q;
    logic [MDW-1:0]  rdata_q;
    logic            r_perr_q, r_ferr_q, rvalid_q;
    logic            brk_q, overrun_q;

    logic [3:0]      size_d;
    logic            par_en_d;
    logic            exp_par_d;
    logic            samp_d;
    logic            break_d;
    logic            complete_d;
    logic            load_d;
    logic            frame_ferr_d;

    // Out-of-range widths collapse to the widest frame.
    assign size_d = (data_size_i < 4'd5 || data_size_i > MDW4) ? MDW4 : data_size_i;

    always_comb begin
        par_en_d  = 1'b0;
        exp_par_d = 1'b0;
        case (par_q)
            3'b001: begin par_en_d = 1'b1; exp_par_d = ~^data_q; end
            3'b010: begin par_en_d = 1'b1; exp_par_d = ^data_q;  end
            3'b100: begin par_en_d = 1'b1; exp_par_d = 1'b0;     end
            3'b101: begin par_en_d = 1'b1; exp_par_d = 1'b1;     end
            default: begin par_en_d = 1'b0; exp_par_d = 1'b0;    end
        endcase
    end

    assign samp_d       = en_i && tick_i && (cnt_q == LAST);
    assign break_d      = (state_q == S_STOP1) && !rx_s2_q && (data_q == '0) &&
                          (!par_en_d || !pbit_q);
    assign complete_d   = samp_d && (((state_q == S_STOP1) && !stop2_q && !break_d) ||
                                     (state_q == S_STOP2));
    assign load_d       = complete_d && (!rvalid_q || rready_i);
    assign frame_ferr_d = ferr_q | ~rx_s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            nbits_q   <= MDW4;
            stop2_q   <= 1'b0;
            par_q     <= 3'b000;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            pbit_q    <= 1'b0;
            rdata_q   <= '0;
            r_perr_q  <= 1'b0;
            r_ferr_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            brk_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_s1_q   <= rx_i;
            rx_s2_q   <= rx_s1_q;
            brk_q     <= 1'b0;
            overrun_q <= 1'b0;
            if (tick_i) prev_q <= rx_s2_q;

            if (rvalid_q && rready_i) rvalid_q <= 1'b0;
            if (load_d) begin
                rdata_q  <= data_q;
                r_perr_q <= perr_q;
                r_ferr_q <= frame_ferr_d;
                rvalid_q <= 1'b1;
            end
            if (complete_d && !load_d) overrun_q <= 1'b1;

            if (!en_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                bit_q   <= '0;
            end else if (tick_i) begin
                case (state_q)
                    S_IDLE: begin
                        // Falling edge only; a line that stays low never re-arms.
                        if (prev_q && !rx_s2_q) begin
                            state_q <= S_START;
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            nbits_q <= size_d;
                            stop2_q <= stop2_i;
                            par_q   <= parity_i;
                            data_q  <= '0;
                            perr_q  <= 1'b0;
                            ferr_q  <= 1'b0;
                            pbit_q  <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (cnt_q == HALF) begin
                            cnt_q   <= '0;
                            state_q <= rx_s2_q ? S_IDLE : S_DATA;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            for (int i = 0; i < MDW; i++) begin
                                if (bit_q == 4'(i)) data_q[i] <= rx_s2_q;
                            end
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == nbits_q - 4'd1) begin
                                state_q <= par_en_d ? S_PARITY : S_STOP1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            pbit_q  <= rx_s2_q;
                            perr_q  <= (rx_s2_q != exp_par_d);
                            state_q <= S_STOP1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_STOP1: begin
                        if (cnt_q == LAST) begin
                            cnt_q <= '0;
                            if (break_d) begin
                                brk_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end else if (stop2_q) begin
                                ferr_q  <= ~rx_s2_q;
                                state_q <= S_STOP2;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_STOP2: begin
                        if (cnt_q == LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign rdata_o   = rdata_q;
    assign r_perr_o  = r_perr_q;
    assign r_ferr_o  = r_ferr_q;
    assign rvalid_o  = rvalid_q;
    assign brk_o     = brk_q;
    assign overrun_o = overrun_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule
